noc_credit_link: RTL and testbench
==================================

Name: noc_credit_link

Overview:
Parametrised rtr-to-rtr link that carries NUM_LINKS independent flit channels between adjacent routers. Each channel has NUM_PIPELINE register stages on the forward flit path and on the reverse credit path. A sender-side credit counter per channel tracks the downstream buffer (FLIT_BUFFER_DEPTH entries) and flags protocol violations. Saturating flit and packet counters per channel provide statistics. The block sits between router_inst outputs and the neighbouring router inputs in the wrapped-router tile, and replaces plain wire links.

Parameters:
NUM_LINKS, 4, number of independent channels (N/S/E/W).
FLIT_WIDTH, 32, flit payload width.
DEST_WIDTH, 6, destination field width (TDEST_WIDTH + TID_WIDTH).
NUM_PIPELINE, 0, register stages per direction; 0 = wire passthrough.
FLIT_BUFFER_DEPTH, 2, downstream input buffer depth; initial credit count.
STAT_WIDTH, 16, width of statistics counters.
CRED_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width (derived).

Ports:
clk_noc  in  1  link clock.
rst_n  in  1  synchronous, active-low reset, sampled on rising clk_noc.
data_in  in  NUM_LINKS x FLIT_WIDTH  upstream flit data.
dest_in  in  NUM_LINKS x DEST_WIDTH  upstream destination.
is_tail_in  in  NUM_LINKS  upstream tail marker.
send_in  in  NUM_LINKS  upstream flit valid.
credit_out  out  NUM_LINKS  credit returned to upstream.
data_out  out  NUM_LINKS x FLIT_WIDTH  downstream flit data.
dest_out  out  NUM_LINKS x DEST_WIDTH  downstream destination.
is_tail_out  out  NUM_LINKS  downstream tail marker.
send_out  out  NUM_LINKS  downstream flit valid.
credit_in  in  NUM_LINKS  credit from downstream.
credit_avail  out  NUM_LINKS  channel credit count > 0.
clear_stats  in  1  synchronous clear of statistics and sticky errors.
flit_count  out  NUM_LINKS x STAT_WIDTH  flits sent, saturating.
pkt_count  out  NUM_LINKS x STAT_WIDTH  tails sent, saturating.
err_overflow  out  NUM_LINKS  sticky: send_in seen with zero credits.
err_credit  out  NUM_LINKS  sticky: credit_in seen with counter at FLIT_BUFFER_DEPTH.

Behaviour:
- Forward path: send_out[i], data_out[i], dest_out[i] and is_tail_out[i] equal the inputs delayed exactly NUM_PIPELINE cycles. Per stage, the valid bit always loads. Data, dest and tail registers load only when the valid bit entering that stage is 1; otherwise they hold.
- Reverse path: credit_out[i] = credit_in[i] delayed exactly NUM_PIPELINE cycles.
- NUM_PIPELINE=0: all paths combinational. Counters and error flags are still registered.
- Credit counter cred[i]: reset to FLIT_BUFFER_DEPTH. Updates on send_in[i] (upstream side, before pipelining) and credit_in[i] (downstream side, before pipelining):
  - send only: cred-1.
  - credit only: cred+1.
  - both or neither: unchanged.
- Boundary, empty: send_in with cred==0 (and no same-cycle credit_in) → cred stays 0, err_overflow set. The flit is still forwarded.
- Boundary, full: credit_in with cred==FLIT_BUFFER_DEPTH (and no same-cycle send) → cred stays at FLIT_BUFFER_DEPTH, err_credit set.
- credit_avail[i] = (cred[i]!=0), registered view of the current counter.
- flit_count increments on each send_in. pkt_count increments on send_in&&is_tail_in. Both saturate at all-ones and do not wrap.
- clear_stats=1: counters and errors go to 0 next cycle. This has priority over an increment in the same cycle. It does not affect cred or the pipelines.
- Reset values, all outputs:
  - send_out=0, credit_out=0, data_out/dest_out/is_tail_out=0.
  - credit_avail=1 (FLIT_BUFFER_DEPTH>=1).
  - flit_count=pkt_count=0, errors=0.
- Reset mid-operation: in-flight flits and credits in the pipelines are discarded, and cred returns to FLIT_BUFFER_DEPTH. Both link endpoints share rst_n, so the downstream buffer is also emptied.
- Elaboration checks: NUM_PIPELINE>=0 and FLIT_BUFFER_DEPTH>=1. A warning is issued when FLIT_BUFFER_DEPTH < 2*NUM_PIPELINE+2, because full throughput cannot be sustained.

Decomposition:
- Package noc_link_pkg holds:
  - parameterised flit struct typedef (data, dest, is_tail);
  - credit-counter width function;
  - saturating-increment function.
- Sub-module noc_link_stage: one generic register stage (valid + gated payload, sync active-low reset). It is instantiated in a generate loop NUM_PIPELINE deep per channel, per direction.
- Top handles the generate-per-link loop, credit counters, statistics and errors.

Test Plan:
1. Reset, NUM_PIPELINE=2, depth 2: rst_n=0 for 2 cycles → all send_out/credit_out 0, credit_avail=4'b1111, counters 0.
2. Link 0: send_in=1 with data 0xDEADBEEF, dest 6'h15, tail=1 at cycle t → send_out[0]=1 and data 0xDEADBEEF at t+2. cred goes 2→1. flit_count=1, pkt_count=1.
3. Two sends without credit, then credit_in at t+5 → credit_avail[0]=0 after the second send and 1 after the credit. credit_out[0] pulses at t+7.
4. Third send at cred=0 → err_overflow[0]=1 and stays set. Flit still emerges 2 cycles later. A same-cycle send+credit with cred=1 leaves cred at 1 and sets no error.
5. Extra credit_in at cred=2 → err_credit=1, cred stays 2. clear_stats → both errors and counters read 0 next cycle, cred unchanged.
6. STAT_WIDTH=4: 17 sends → flit_count=4'hF, not 0. NUM_PIPELINE=0 variant: send_out equals send_in in the same cycle.

Source files
------------

// File: rtl/noc_link_pkg.sv
// Shared helpers for the credit-based router-to-router link.
package noc_link_pkg;

    function automatic int cred_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? max_v : v + 64'd1;
    endfunction

endpackage

// File: rtl/noc_credit_link_if.sv
// Flit/credit handshake bundle for all channels of one link side.
interface noc_credit_link_if #(
    parameter int NUM_LINKS  = 4,
    parameter int FLIT_WIDTH = 32,
    parameter int DEST_WIDTH = 6
);
    logic [NUM_LINKS-1:0][FLIT_WIDTH-1:0] data;
    logic [NUM_LINKS-1:0][DEST_WIDTH-1:0] dest;
    logic [NUM_LINKS-1:0]                 is_tail;
    logic [NUM_LINKS-1:0]                 send;
    logic [NUM_LINKS-1:0]                 credit;

    modport master (output data, dest, is_tail, send, input  credit);
    modport slave  (input  data, dest, is_tail, send, output credit);
endinterface

// File: rtl/noc_link_stage.sv
// One link register stage: valid always loads, payload loads only with valid.
module noc_link_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vld_i,
    input  logic [W-1:0] pay_i,
    output logic         vld_o,
    output logic [W-1:0] pay_o
);
    logic         vld_q, vld_d;
    logic [W-1:0] pay_q, pay_d;

    always_comb begin
        vld_d = vld_i;
        pay_d = vld_i ? pay_i : pay_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            pay_q <= '0;
        end else begin
            vld_q <= vld_d;
            pay_q <= pay_d;
        end
    end

    assign vld_o = vld_q;
    assign pay_o = pay_q;
endmodule

// File: rtl/noc_credit_link.sv
// Pipelined credit-based link: per-channel flit/credit delay lines, sender
// credit tracking with protocol-error flags, and saturating statistics.
module noc_credit_link
    import noc_link_pkg::*;
#(
    parameter int NUM_LINKS         = 4,
    parameter int FLIT_WIDTH        = 32,
    parameter int DEST_WIDTH        = 6,
    parameter int NUM_PIPELINE      = 0,
    parameter int FLIT_BUFFER_DEPTH = 2,
    parameter int STAT_WIDTH        = 16,
    parameter int CRED_WIDTH        = cred_width(FLIT_BUFFER_DEPTH)
) (
    input  logic                                 clk_noc,
    input  logic                                 rst_n,
    noc_credit_link_if.slave                     up,
    noc_credit_link_if.master                    dn,
    input  logic                                 clear_stats,
    output logic [NUM_LINKS-1:0]                 credit_avail,
    output logic [NUM_LINKS-1:0][STAT_WIDTH-1:0] flit_count,
    output logic [NUM_LINKS-1:0][STAT_WIDTH-1:0] pkt_count,
    output logic [NUM_LINKS-1:0]                 err_overflow,
    output logic [NUM_LINKS-1:0]                 err_credit
);
    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  is_tail;
    } flit_t;

    localparam int                    FW       = $bits(flit_t);
    localparam logic [CRED_WIDTH-1:0] CRED_MAX = CRED_WIDTH'(FLIT_BUFFER_DEPTH);

    if (NUM_PIPELINE < 0) begin : g_chk_pipe
        $error("noc_credit_link: NUM_PIPELINE must be >= 0");
    end
    if (FLIT_BUFFER_DEPTH < 1) begin : g_chk_depth
        $error("noc_credit_link: FLIT_BUFFER_DEPTH must be >= 1");
    end
    // Round trip is 2*NUM_PIPELINE+2 cycles; a shallower buffer throttles the link.
    if (FLIT_BUFFER_DEPTH < 2*NUM_PIPELINE + 2) begin : g_warn_tput
        $warning("noc_credit_link: FLIT_BUFFER_DEPTH < 2*NUM_PIPELINE+2, full throughput not sustainable");
    end

    for (genvar i = 0; i < NUM_LINKS; i++) begin : g_link
        logic          fwd_vld [NUM_PIPELINE+1];
        logic [FW-1:0] fwd_pay [NUM_PIPELINE+1];
        logic          crd_vld [NUM_PIPELINE+1];
        logic          crd_pay [NUM_PIPELINE+1];
        flit_t         flit_in, flit_out;

        assign flit_in    = '{data: up.data[i], dest: up.dest[i], is_tail: up.is_tail[i]};
        assign fwd_vld[0] = up.send[i];
        assign fwd_pay[0] = flit_in;
        assign crd_vld[0] = dn.credit[i];
        assign crd_pay[0] = dn.credit[i];

        for (genvar s = 0; s < NUM_PIPELINE; s++) begin : g_stage
            noc_link_stage #(.W(FW)) u_fwd (
                .clk(clk_noc), .rst_n(rst_n),
                .vld_i(fwd_vld[s]),   .pay_i(fwd_pay[s]),
                .vld_o(fwd_vld[s+1]), .pay_o(fwd_pay[s+1])
            );
            noc_link_stage #(.W(1)) u_crd (
                .clk(clk_noc), .rst_n(rst_n),
                .vld_i(crd_vld[s]),   .pay_i(crd_pay[s]),
                .vld_o(crd_vld[s+1]), .pay_o(crd_pay[s+1])
            );
        end

        assign flit_out       = flit_t'(fwd_pay[NUM_PIPELINE]);
        assign dn.send[i]     = fwd_vld[NUM_PIPELINE];
        assign dn.data[i]     = flit_out.data;
        assign dn.dest[i]     = flit_out.dest;
        assign dn.is_tail[i]  = flit_out.is_tail;
        // The credit payload only ever latches a 1, so it is 1 whenever valid is.
        assign up.credit[i]   = crd_vld[NUM_PIPELINE] & crd_pay[NUM_PIPELINE];

        logic [CRED_WIDTH-1:0] cred_q, cred_d;
        logic [STAT_WIDTH-1:0] flit_cnt_q, flit_cnt_d;
        logic [STAT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
        logic                  err_ovf_q, err_ovf_d;
        logic                  err_crd_q, err_crd_d;

        always_comb begin
            cred_d     = cred_q;
            flit_cnt_d = flit_cnt_q;
            pkt_cnt_d  = pkt_cnt_q;
            err_ovf_d  = err_ovf_q;
            err_crd_d  = err_crd_q;
            if (up.send[i] && !dn.credit[i]) begin
                if (cred_q == '0) err_ovf_d = 1'b1;
                else              cred_d    = cred_q - CRED_WIDTH'(1);
            end else if (dn.credit[i] && !up.send[i]) begin
                if (cred_q == CRED_MAX) err_crd_d = 1'b1;
                else                    cred_d    = cred_q + CRED_WIDTH'(1);
            end
            if (up.send[i]) begin
                flit_cnt_d = STAT_WIDTH'(sat_inc(64'(flit_cnt_q), STAT_WIDTH));
                if (up.is_tail[i]) pkt_cnt_d = STAT_WIDTH'(sat_inc(64'(pkt_cnt_q), STAT_WIDTH));
            end
            // Clearing wins over any same-cycle increment or error.
            if (clear_stats) begin
                flit_cnt_d = '0;
                pkt_cnt_d  = '0;
                err_ovf_d  = 1'b0;
                err_crd_d  = 1'b0;
            end
        end

        always_ff @(posedge clk_noc) begin
            if (!rst_n) begin
                cred_q     <= CRED_MAX;
                flit_cnt_q <= '0;
                pkt_cnt_q  <= '0;
                err_ovf_q  <= 1'b0;
                err_crd_q  <= 1'b0;
            end else begin
                cred_q     <= cred_d;
                flit_cnt_q <= flit_cnt_d;
                pkt_cnt_q  <= pkt_cnt_d;
                err_ovf_q  <= err_ovf_d;
                err_crd_q  <= err_crd_d;
            end
        end

        assign credit_avail[i] = (cred_q != '0);
        assign flit_count[i]   = flit_cnt_q;
        assign pkt_count[i]    = pkt_cnt_q;
        assign err_overflow[i] = err_ovf_q;
        assign err_credit[i]   = err_crd_q;
    end
endmodule

// File: tb/tb_noc_credit_link.sv
// Scoreboard bench: two link instances (2-stage/16-bit stats, passthrough/4-bit stats)
// driven with the same directed and random traffic, checked against a queue model.
`timescale 1ns/1ps
module tb_noc_credit_link;
    localparam int NL    = 4;
    localparam int FWID  = 32;
    localparam int DW    = 6;
    localparam int NDUT  = 2;
    localparam int DEPTH = 2;
    localparam logic [NL-1:0] L0 = NL'(1);
    localparam logic [NL-1:0] NO = '0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst_n, clear_stats;
    logic [NL-1:0][FWID-1:0]   data_in;
    logic [NL-1:0][DW-1:0]     dest_in;
    logic [NL-1:0]             tail_in, send_in, credit_in;

    noc_credit_link_if #(.NUM_LINKS(NL), .FLIT_WIDTH(FWID), .DEST_WIDTH(DW)) up_a(), dn_a(), up_b(), dn_b();

    assign up_a.data = data_in;  assign up_a.dest = dest_in;
    assign up_a.is_tail = tail_in; assign up_a.send = send_in;
    assign dn_a.credit = credit_in;
    assign up_b.data = data_in;  assign up_b.dest = dest_in;
    assign up_b.is_tail = tail_in; assign up_b.send = send_in;
    assign dn_b.credit = credit_in;

    logic [NL-1:0]         avail_a, avail_b, eo_a, eo_b, ec_a, ec_b;
    logic [NL-1:0][15:0]   fc_a, pc_a;
    logic [NL-1:0][3:0]    fc_b, pc_b;

    noc_credit_link #(.NUM_LINKS(NL), .FLIT_WIDTH(FWID), .DEST_WIDTH(DW), .NUM_PIPELINE(2),
                      .FLIT_BUFFER_DEPTH(DEPTH), .STAT_WIDTH(16)) dut_a (
        .clk_noc(clk), .rst_n(rst_n), .up(up_a), .dn(dn_a), .clear_stats(clear_stats),
        .credit_avail(avail_a), .flit_count(fc_a), .pkt_count(pc_a),
        .err_overflow(eo_a), .err_credit(ec_a)
    );

    noc_credit_link #(.NUM_LINKS(NL), .FLIT_WIDTH(FWID), .DEST_WIDTH(DW), .NUM_PIPELINE(0),
                      .FLIT_BUFFER_DEPTH(DEPTH), .STAT_WIDTH(4)) dut_b (
        .clk_noc(clk), .rst_n(rst_n), .up(up_b), .dn(dn_b), .clear_stats(clear_stats),
        .credit_avail(avail_b), .flit_count(fc_b), .pkt_count(pc_b),
        .err_overflow(eo_b), .err_credit(ec_b)
    );

    // Reference model: expected flit/credit arrivals as timestamped queues,
    // credit level as a clamped integer, statistics as saturating integers.
    typedef struct {
        int              due;
        logic [FWID-1:0] data;
        logic [DW-1:0]   dest;
        logic            tail;
    } exp_t;

    int   np     [NDUT] = '{2, 0};
    int   sw_max [NDUT] = '{65535, 15};
    exp_t fq [NDUT*NL][$];
    int   cq [NDUT*NL][$];
    int   m_cred [NDUT][NL];
    int   m_flit [NDUT][NL];
    int   m_pkt  [NDUT][NL];
    bit   m_eo   [NDUT][NL];
    bit   m_ec   [NDUT][NL];
    bit   m_rst;
    bit   mon_en = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int d, input int i,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d link%0d cycle %0d: got %0h expected %0h", name, d, i, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        int nxt;
        m_rst = !rst_n;
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < NL; i++) begin
                if (!rst_n) begin
                    m_cred[d][i] = DEPTH;
                    m_flit[d][i] = 0;
                    m_pkt[d][i]  = 0;
                    m_eo[d][i]   = 1'b0;
                    m_ec[d][i]   = 1'b0;
                    fq[d*NL+i].delete();
                    cq[d*NL+i].delete();
                end else begin
                    nxt = m_cred[d][i] - int'(send_in[i]) + int'(credit_in[i]);
                    if (nxt < 0)     begin nxt = 0;     m_eo[d][i] = 1'b1; end
                    if (nxt > DEPTH) begin nxt = DEPTH; m_ec[d][i] = 1'b1; end
                    m_cred[d][i] = nxt;
                    if (send_in[i] && m_flit[d][i] < sw_max[d]) m_flit[d][i]++;
                    if (send_in[i] && tail_in[i] && m_pkt[d][i] < sw_max[d]) m_pkt[d][i]++;
                    if (clear_stats) begin
                        m_flit[d][i] = 0;
                        m_pkt[d][i]  = 0;
                        m_eo[d][i]   = 1'b0;
                        m_ec[d][i]   = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic [NL-1:0] s, input logic [NL-1:0] c,
                        input logic [NL-1:0] t, input logic clr,
                        input logic [FWID-1:0] d0, input logic [DW-1:0] e0);
        @(posedge clk);
        model_edge();
        mon_en = 1'b1;
        #1;
        rst_n       = r;
        send_in     = r ? s : NO;
        credit_in   = r ? c : NO;
        tail_in     = t;
        clear_stats = clr;
        for (int i = 0; i < NL; i++) begin
            data_in[i] = (i == 0) ? d0 : $urandom();
            dest_in[i] = (i == 0) ? e0 : DW'($urandom());
        end
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < NL; i++) begin
                if (send_in[i])   fq[d*NL+i].push_back('{cyc + np[d], data_in[i], dest_in[i], tail_in[i]});
                if (credit_in[i]) cq[d*NL+i].push_back(cyc + np[d]);
            end
        end
    endtask

    task automatic idle();
        step(1'b1, NO, NO, NO, 1'b0, $urandom(), DW'($urandom()));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < NDUT; d++) begin
                for (int i = 0; i < NL; i++) begin
                    int              k;
                    bit              exp_f, exp_c;
                    exp_t            e;
                    logic            so, co, to;
                    logic [FWID-1:0] dv;
                    logic [DW-1:0]   ev;
                    k  = d*NL + i;
                    so = (d == 0) ? dn_a.send[i]    : dn_b.send[i];
                    co = (d == 0) ? up_a.credit[i]  : up_b.credit[i];
                    dv = (d == 0) ? dn_a.data[i]    : dn_b.data[i];
                    ev = (d == 0) ? dn_a.dest[i]    : dn_b.dest[i];
                    to = (d == 0) ? dn_a.is_tail[i] : dn_b.is_tail[i];

                    exp_f = (fq[k].size() > 0) && (fq[k][0].due <= cyc);
                    check("send_out", d, i, 64'(so), 64'(exp_f));
                    if (exp_f) begin
                        e = fq[k].pop_front();
                        if (so) begin
                            check("data_out", d, i, 64'(dv), 64'(e.data));
                            check("dest_out", d, i, 64'(ev), 64'(e.dest));
                            check("is_tail_out", d, i, 64'(to), 64'(e.tail));
                        end
                    end

                    exp_c = (cq[k].size() > 0) && (cq[k][0] <= cyc);
                    check("credit_out", d, i, 64'(co), 64'(exp_c));
                    if (exp_c) void'(cq[k].pop_front());

                    if (m_rst && d == 0)
                        check("data_out_reset", d, i, 64'({dv, ev, to}), 64'(0));

                    check("credit_avail", d, i, 64'((d == 0) ? avail_a[i] : avail_b[i]), 64'(m_cred[d][i] != 0));
                    check("flit_count",   d, i, (d == 0) ? 64'(fc_a[i]) : 64'(fc_b[i]), 64'(m_flit[d][i]));
                    check("pkt_count",    d, i, (d == 0) ? 64'(pc_a[i]) : 64'(pc_b[i]), 64'(m_pkt[d][i]));
                    check("err_overflow", d, i, 64'((d == 0) ? eo_a[i] : eo_b[i]), 64'(m_eo[d][i]));
                    check("err_credit",   d, i, 64'((d == 0) ? ec_a[i] : ec_b[i]), 64'(m_ec[d][i]));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; clear_stats = 1'b0;
        send_in = NO; credit_in = NO; tail_in = NO;
        data_in = '0; dest_in = '0;

        repeat (2) step(1'b0, NO, NO, NO, 1'b0, 32'h0, 6'h0);

        // Single tagged flit, then walk link 0 through empty/full boundaries.
        step(1'b1, L0, NO, L0, 1'b0, 32'hDEADBEEF, 6'h15);
        repeat (4) idle();
        step(1'b1, NO, L0, NO, 1'b0, 32'h1, 6'h1);
        step(1'b1, L0, NO, NO, 1'b0, 32'h11111111, 6'h2);
        step(1'b1, L0, NO, L0, 1'b0, 32'h22222222, 6'h3);
        repeat (2) idle();
        step(1'b1, NO, L0, NO, 1'b0, 32'h2, 6'h0);
        repeat (3) idle();
        step(1'b1, L0, NO, NO, 1'b0, 32'h33333333, 6'h4);
        step(1'b1, L0, NO, L0, 1'b0, 32'h44444444, 6'h5);
        repeat (2) idle();
        step(1'b1, NO, L0, NO, 1'b0, 32'h3, 6'h0);
        step(1'b1, L0, L0, NO, 1'b0, 32'h55555555, 6'h6);
        step(1'b1, NO, L0, NO, 1'b0, 32'h4, 6'h0);
        step(1'b1, NO, L0, NO, 1'b0, 32'h5, 6'h0);
        repeat (2) idle();
        step(1'b1, NO, NO, NO, 1'b1, 32'h6, 6'h0);
        repeat (2) idle();

        // Long burst without clearing so the 4-bit counters must saturate.
        for (int j = 0; j < 20; j++)
            step(1'b1, L0, L0, NL'(j & 1), 1'b0, $urandom(), DW'($urandom()));
        repeat (3) idle();

        // Reset while flits and credits are in flight.
        step(1'b1, '1, '1, '1, 1'b0, $urandom(), DW'($urandom()));
        step(1'b1, '1, NO, NO, 1'b0, $urandom(), DW'($urandom()));
        repeat (2) step(1'b0, NO, NO, NO, 1'b0, 32'h0, 6'h0);
        repeat (3) idle();

        for (int j = 0; j < 3000; j++)
            step($urandom_range(0, 499) != 0, NL'($urandom()), NL'($urandom()), NL'($urandom()),
                 $urandom_range(0, 127) == 0, $urandom(), DW'($urandom()));

        repeat (6) idle();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
